// File: rtl/memstream_pkg.sv
// Shared definitions for the memstream weight-streamer buffers.
package memstream_pkg;

    // Words still in flight in the streamer read pipeline after it sees afull.
    localparam int unsigned AFULL_MARGIN = 3;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/memstream_fifo_ram.sv
// Simple dual-port storage array: one write port, one registered-output read port.
module memstream_fifo_ram
    import memstream_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 15,
    parameter int unsigned ADDR_W    = 4,
    parameter string       RAM_STYLE = "auto"
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/memstream_strm_fifo.sv
// Per-stream output buffer: DEPTH-1 word array plus an output head register, with a
// registered almost-full flag that stalls the upstream streamer early.
module memstream_strm_fifo
    import memstream_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AFULL_THRESH = DEPTH - AFULL_MARGIN,
    parameter string       RAM_STYLE    = "auto"
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [WIDTH-1:0]           s_axis_tdata,
    output logic                       s_axis_afull,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [WIDTH-1:0]           m_axis_tdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf
);

    localparam int unsigned CNT_W     = clog2(DEPTH + 1);
    localparam int unsigned ARR_DEPTH = DEPTH - 1;
    localparam int unsigned PTR_W     = clog2(ARR_DEPTH);

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(ARR_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] arr_cnt;
    logic             out_valid_q, out_valid_d;
    logic             src_byp_q, src_byp_d;
    logic [WIDTH-1:0] byp_data_q;
    logic [WIDTH-1:0] ram_rdata;
    logic             tready_q, afull_q, ovf_q, ovf_d;
    logic             wr_en, rd_en, out_free, load_arr, load_byp, arr_we;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_en    = s_axis_tvalid && tready_q;
        rd_en    = out_valid_q && m_axis_tready;
        out_free = !out_valid_q || rd_en;
        arr_cnt  = count_q - CNT_W'(out_valid_q);
        // The array has priority over bypass so ordering is preserved.
        load_arr = out_free && (arr_cnt != '0);
        load_byp = out_free && (arr_cnt == '0) && wr_en;
        arr_we   = wr_en && !load_byp;

        count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
        wr_ptr_d = arr_we ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = load_arr ? ptr_inc(rd_ptr_q) : rd_ptr_q;

        out_valid_d = out_valid_q;
        if (load_arr || load_byp) begin
            out_valid_d = 1'b1;
        end else if (rd_en) begin
            out_valid_d = 1'b0;
        end

        src_byp_d = src_byp_q;
        if (load_byp) begin
            src_byp_d = 1'b1;
        end else if (load_arr) begin
            src_byp_d = 1'b0;
        end

        ovf_d = ovf_q || (s_axis_tvalid && !tready_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            src_byp_q   <= 1'b0;
            byp_data_q  <= '0;
            tready_q    <= 1'b0;
            afull_q     <= 1'b1;
            ovf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            src_byp_q   <= src_byp_d;
            if (load_byp) begin
                byp_data_q <= s_axis_tdata;
            end
            tready_q    <= (count_d < FULL_CNT);
            afull_q     <= (count_d >= AFULL_CNT);
            ovf_q       <= ovf_d;
        end
    end

    memstream_fifo_ram #(
        .WIDTH     (WIDTH),
        .DEPTH     (ARR_DEPTH),
        .ADDR_W    (PTR_W),
        .RAM_STYLE (RAM_STYLE)
    ) u_ram (
        .clk   (aclk),
        .we    (arr_we),
        .waddr (wr_ptr_q),
        .wdata (s_axis_tdata),
        .re    (load_arr),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // The head word lives either in the RAM read register or in the bypass register.
    assign m_axis_tdata  = src_byp_q ? byp_data_q : ram_rdata;
    assign m_axis_tvalid = out_valid_q;
    assign s_axis_tready = tready_q;
    assign s_axis_afull  = afull_q;
    assign count         = count_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_memstream_strm_fifo.sv
// Directed and table-driven bench for memstream_strm_fifo (WIDTH=32, DEPTH=16, AFULL_THRESH=13).
module tb_memstream_strm_fifo;

    localparam int unsigned W = 32;
    localparam int unsigned D = 16;
    localparam int unsigned T = 13;

    logic          aclk;
    logic          aresetn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_afull;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic [4:0]    count;
    logic          ovf;

    memstream_strm_fifo #(
        .WIDTH        (W),
        .DEPTH        (D),
        .AFULL_THRESH (T),
        .RAM_STYLE    ("auto")
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_afull  (s_axis_afull),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .count         (count),
        .ovf           (ovf)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        tv;
        logic [31:0] d;
        logic        tr;
        int          e_mv;
        logic [31:0] e_d;
        int          e_cnt;
        int          e_rdy;
        int          e_af;
        int          e_ovf;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    int          n_cmp;
    int          n_err;
    int          n_cons;

    function automatic vec_t mk(input logic tv, input logic [31:0] d, input logic tr,
                                input int e_mv, input logic [31:0] e_d, input int e_cnt,
                                input int e_rdy, input int e_af, input int e_ovf);
        vec_t v;
        v.tv = tv; v.d = d; v.tr = tr;
        v.e_mv = e_mv; v.e_d = e_d; v.e_cnt = e_cnt;
        v.e_rdy = e_rdy; v.e_af = e_af; v.e_ovf = e_ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, score consumed/accepted words, return after posedge+1.
    task automatic cyc(input logic tv, input logic [31:0] d, input logic tr, output logic acc);
        logic [31:0] e;
        @(negedge aclk);
        s_axis_tvalid = tv;
        s_axis_tdata  = d;
        m_axis_tready = tr;
        acc = tv && s_axis_tready;
        if (m_axis_tvalid && tr) begin
            e = 32'hxxxx_xxxx;
            if (sb.size() > 0) e = sb.pop_front();
            chk("order", m_axis_tdata, e);
            n_cons++;
        end
        if (acc) sb.push_back(d);
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        sb.delete();
    endtask

    initial begin
        logic acc;
        logic tv, tr, af;
        int   sent, cycles, base, credit;

        n_cmp = 0; n_err = 0; n_cons = 0;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_mvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_afull",  32'(s_axis_afull), 1);
        chk("rst_count",  32'(count), 0);
        chk("rst_ovf",    32'(ovf), 0);

        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("rel_tready", 32'(s_axis_tready), 1);
        chk("rel_afull",  32'(s_axis_afull), 0);
        chk("rel_count",  32'(count), 0);
        chk("rel_mvalid", 32'(m_axis_tvalid), 0);

        // Single word, then fill 0..15 with consumer stalled, overflow attempt, full drain.
        vecs.push_back(mk(1'b1, 32'hDEADBEEF, 1'b1, 1, 32'hDEADBEEF, 1, 1, 0, 0));
        vecs.push_back(mk(1'b0, 32'h0, 1'b1, 0, 32'h0, 0, 1, 0, 0));
        for (int i = 0; i < 16; i++) begin
            vecs.push_back(mk(1'b1, 32'(i), 1'b0, 1, 32'h0, i + 1,
                              ((i + 1) < 16) ? 1 : 0, ((i + 1) >= 13) ? 1 : 0, 0));
        end
        vecs.push_back(mk(1'b1, 32'd99, 1'b0, 1, 32'h0, 16, 0, 1, 1));
        for (int k = 1; k <= 16; k++) begin
            vecs.push_back(mk(1'b0, 32'h0, 1'b1, (k < 16) ? 1 : 0, 32'(k), 16 - k, 1,
                              ((16 - k) >= 13) ? 1 : 0, 1));
        end

        foreach (vecs[i]) begin
            @(negedge aclk);
            s_axis_tvalid = vecs[i].tv;
            s_axis_tdata  = vecs[i].d;
            m_axis_tready = vecs[i].tr;
            @(posedge aclk);
            #1;
            chk($sformatf("v%0d_mvalid", i), 32'(m_axis_tvalid), 32'(vecs[i].e_mv));
            if (vecs[i].e_mv != 0) chk($sformatf("v%0d_mdata", i), m_axis_tdata, vecs[i].e_d);
            chk($sformatf("v%0d_count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_tready", i), 32'(s_axis_tready), 32'(vecs[i].e_rdy));
            chk($sformatf("v%0d_afull", i), 32'(s_axis_afull), 32'(vecs[i].e_af));
            chk($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].e_ovf));
        end

        // Asynchronous reset mid-burst at count 9 (ovf is still set from above).
        for (int i = 0; i < 9; i++) cyc(1'b1, 32'h500 + 32'(i), 1'b0, acc);
        chk("mr_count_pre", 32'(count), 9);
        @(negedge aclk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h600;
        m_axis_tready = 1'b1;
        #2 aresetn = 1'b0;
        #1;
        chk("mr_mvalid", 32'(m_axis_tvalid), 0);
        chk("mr_tready", 32'(s_axis_tready), 0);
        chk("mr_afull",  32'(s_axis_afull), 1);
        chk("mr_count",  32'(count), 0);
        chk("mr_ovf",    32'(ovf), 0);
        s_axis_tvalid = 1'b0;
        sb.delete();
        @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'h0, 1'b1, acc);
            chk("mr_post_mvalid", 32'(m_axis_tvalid), 0);
            chk("mr_post_count", 32'(count), 0);
        end

        // From full, stream 100 words with the consumer always ready.
        base = n_cons;
        for (int i = 0; i < 16; i++) cyc(1'b1, 32'd1000 + 32'(i), 1'b0, acc);
        chk("st_full_count", 32'(count), 16);
        chk("st_full_tready", 32'(s_axis_tready), 0);
        sent = 0;
        cycles = 0;
        while (sent < 100 && cycles < 300) begin
            chk("st_bubble", 32'(m_axis_tvalid), 1);
            cyc(s_axis_tready, 32'd2000 + 32'(sent), 1'b1, acc);
            if (acc) sent++;
            chk("st_count", 32'(count), 15);
            cycles++;
        end
        chk("st_sent", 32'(sent), 100);
        cycles = 0;
        while (m_axis_tvalid && cycles < 40) begin
            cyc(1'b0, 32'h0, 1'b1, acc);
            cycles++;
        end
        chk("st_end_mvalid", 32'(m_axis_tvalid), 0);
        chk("st_end_count", 32'(count), 0);
        chk("st_consumed", 32'(n_cons - base), 116);
        chk("st_ovf", 32'(ovf), 0);

        // Random traffic; the model streamer sends at most 3 words once afull is seen.
        do_reset();
        base = n_cons;
        sent = 0;
        cycles = 0;
        credit = 3;
        while (sent < 10000 && cycles < 80000) begin
            af = s_axis_afull;
            if (!af) credit = 3;
            tv = ($urandom_range(1, 0) == 1) && (credit > 0);
            tr = ($urandom_range(1, 0) == 1);
            cyc(tv, $urandom, tr, acc);
            if (acc) begin
                sent++;
                if (af) credit--;
            end
            cycles++;
        end
        chk("rnd_sent", 32'(sent), 10000);
        cycles = 0;
        while (m_axis_tvalid && cycles < 100) begin
            cyc(1'b0, 32'h0, 1'b1, acc);
            cycles++;
        end
        chk("rnd_ovf", 32'(ovf), 0);
        chk("rnd_count", 32'(count), 0);
        chk("rnd_consumed", 32'(n_cons - base), 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
